// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard/forwarding controller.
// Operand use-timing codes and producer ready-stage codes.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] USE_NONE = 2'd0;
  localparam logic [1:0] USE_ID   = 2'd1;
  localparam logic [1:0] USE_EX   = 2'd2;

  localparam int unsigned RDY_ALU  = 1;
  localparam int unsigned RDY_LOAD = 2;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_pick.sv
// Youngest-writer priority selector: finds the lowest-index slot at or above LO
// that writes register src, returning that slot's index and ready stage.
module pipe_hazard_ctrl_fwd_pick #(
  parameter int unsigned NSTG = 3,
  parameter int unsigned AW   = 5,
  parameter int unsigned SW_  = 3,
  parameter int unsigned LO   = 0
) (
  input  logic [NSTG-1:0]     valid,
  input  logic [NSTG-1:0]     wr,
  input  logic [NSTG*AW-1:0]  dst,
  input  logic [NSTG*SW_-1:0] rdy,
  input  logic [AW-1:0]       src,
  output logic                hit_c,
  output logic [SW_-1:0]      idx_c,
  output logic [SW_-1:0]      rdy_c
);

  // Scan oldest to youngest so the youngest match is the last assignment.
  always_comb begin
    hit_c = 1'b0;
    idx_c = '0;
    rdy_c = '0;
    for (int k = int'(NSTG) - 1; k >= 0; k--) begin
      if (k >= int'(LO) && src != '0 && valid[k] && wr[k] &&
          dst[k*AW +: AW] == src) begin
        hit_c = 1'b1;
        idx_c = SW_'(k);
        rdy_c = rdy[k*SW_ +: SW_];
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: shadow tag pipeline of post-decode slots,
// decode stall generation, ID/EX operand forwarding and a stall counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned NSTG = 3,
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned SW_  = $clog2(NSTG) + 1,
  parameter int unsigned CNTW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic                id_wr,
  input  logic [AW-1:0]       id_dst,
  input  logic [SW_-1:0]      id_rdy,
  input  logic [AW-1:0]       id_rs,
  input  logic [AW-1:0]       id_rt,
  input  logic [1:0]          id_rs_use,
  input  logic [1:0]          id_rt_use,
  input  logic                flush,
  input  logic [NSTG*DW-1:0]  stg_data,
  input  logic [DW-1:0]       id_rs_dat,
  input  logic [DW-1:0]       id_rt_dat,
  input  logic [DW-1:0]       ex_rs_dat,
  input  logic [DW-1:0]       ex_rt_dat,
  output logic                stall,
  output logic [DW-1:0]       id_rs_fwd,
  output logic [DW-1:0]       id_rt_fwd,
  output logic [DW-1:0]       ex_rs_fwd,
  output logic [DW-1:0]       ex_rt_fwd,
  output logic                ex_rs_hit,
  output logic                ex_rt_hit,
  output logic [CNTW-1:0]     stall_cnt
);

  localparam int unsigned SW1 = SW_ + 1;

  // Slot storage; only slot 0 needs its source tags (the EX consumer).
  logic [NSTG-1:0]     s_valid;
  logic [NSTG-1:0]     s_wr;
  logic [NSTG*AW-1:0]  s_dst;
  logic [NSTG*SW_-1:0] s_rdy;
  logic [AW-1:0]       s_rs0;
  logic [AW-1:0]       s_rt0;

  logic           irs_hit, irt_hit, ers_hit, ert_hit;
  logic [SW_-1:0] irs_idx, irt_idx, ers_idx, ert_idx;
  logic [SW_-1:0] irs_rdy, irt_rdy, ers_rdy, ert_rdy;
  logic           haz_rs, haz_rt;

  function automatic logic [DW-1:0] slot_data(input logic [NSTG*DW-1:0] data,
                                              input logic [SW_-1:0] idx);
    slot_data = '0;
    for (int k = 0; k < int'(NSTG); k++) begin
      if (idx == SW_'(k)) slot_data = data[k*DW +: DW];
    end
  endfunction

  pipe_hazard_ctrl_fwd_pick #(.NSTG(NSTG), .AW(AW), .SW_(SW_), .LO(0)) u_pick_id_rs (
    .valid(s_valid), .wr(s_wr), .dst(s_dst), .rdy(s_rdy), .src(id_rs),
    .hit_c(irs_hit), .idx_c(irs_idx), .rdy_c(irs_rdy)
  );

  pipe_hazard_ctrl_fwd_pick #(.NSTG(NSTG), .AW(AW), .SW_(SW_), .LO(0)) u_pick_id_rt (
    .valid(s_valid), .wr(s_wr), .dst(s_dst), .rdy(s_rdy), .src(id_rt),
    .hit_c(irt_hit), .idx_c(irt_idx), .rdy_c(irt_rdy)
  );

  pipe_hazard_ctrl_fwd_pick #(.NSTG(NSTG), .AW(AW), .SW_(SW_), .LO(1)) u_pick_ex_rs (
    .valid(s_valid), .wr(s_wr), .dst(s_dst), .rdy(s_rdy), .src(s_rs0),
    .hit_c(ers_hit), .idx_c(ers_idx), .rdy_c(ers_rdy)
  );

  pipe_hazard_ctrl_fwd_pick #(.NSTG(NSTG), .AW(AW), .SW_(SW_), .LO(1)) u_pick_ex_rt (
    .valid(s_valid), .wr(s_wr), .dst(s_dst), .rdy(s_rdy), .src(s_rt0),
    .hit_c(ert_hit), .idx_c(ert_idx), .rdy_c(ert_rdy)
  );

  // EX-use sources only need the producer ready one stage later.
  always_comb begin
    haz_rs = 1'b0;
    haz_rt = 1'b0;
    if (irs_hit && id_rs_use == USE_ID && irs_idx < irs_rdy) haz_rs = 1'b1;
    if (irs_hit && id_rs_use == USE_EX &&
        SW1'(irs_idx) + SW1'(1) < SW1'(irs_rdy)) haz_rs = 1'b1;
    if (irt_hit && id_rt_use == USE_ID && irt_idx < irt_rdy) haz_rt = 1'b1;
    if (irt_hit && id_rt_use == USE_EX &&
        SW1'(irt_idx) + SW1'(1) < SW1'(irt_rdy)) haz_rt = 1'b1;
    stall = id_valid & ~flush & (haz_rs | haz_rt);
  end

  always_comb begin
    id_rs_fwd = id_rs_dat;
    id_rt_fwd = id_rt_dat;
    if (irs_hit && id_rs_use == USE_ID) id_rs_fwd = slot_data(stg_data, irs_idx);
    if (irt_hit && id_rt_use == USE_ID) id_rt_fwd = slot_data(stg_data, irt_idx);
  end

  // EX data is taken only from a producer that has reached its ready stage.
  always_comb begin
    ex_rs_hit = ers_hit && (ers_idx >= ers_rdy);
    ex_rt_hit = ert_hit && (ert_idx >= ert_rdy);
    ex_rs_fwd = ex_rs_hit ? slot_data(stg_data, ers_idx) : ex_rs_dat;
    ex_rt_fwd = ex_rt_hit ? slot_data(stg_data, ert_idx) : ex_rt_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_valid   <= '0;
      s_wr      <= '0;
      s_dst     <= '0;
      s_rdy     <= '0;
      s_rs0     <= '0;
      s_rt0     <= '0;
      stall_cnt <= '0;
    end else begin
      s_valid <= {s_valid[NSTG-2:0], id_valid & ~flush & ~stall};
      s_wr    <= {s_wr[NSTG-2:0], id_wr};
      s_dst   <= {s_dst[(NSTG-1)*AW-1:0], id_dst};
      s_rdy   <= {s_rdy[(NSTG-1)*SW_-1:0], id_rdy};
      s_rs0   <= id_rs;
      s_rt0   <= id_rt;
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: scenario tasks push expected
// values to a scoreboard queue and pop them when the outputs are sampled.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int unsigned NSTG = 8;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned SW_  = $clog2(NSTG) + 1;
  localparam int unsigned CNTW = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                id_valid, id_wr, flush;
  logic [AW-1:0]       id_dst, id_rs, id_rt;
  logic [SW_-1:0]      id_rdy;
  logic [1:0]          id_rs_use, id_rt_use;
  logic [NSTG*DW-1:0]  stg_data;
  logic [DW-1:0]       id_rs_dat, id_rt_dat, ex_rs_dat, ex_rt_dat;
  logic                stall, ex_rs_hit, ex_rt_hit;
  logic [DW-1:0]       id_rs_fwd, id_rt_fwd, ex_rs_fwd, ex_rt_fwd;
  logic [CNTW-1:0]     stall_cnt;

  typedef struct {
    string         name;
    logic [DW-1:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_pass  = 0;
  int   n_total = 0;

  pipe_hazard_ctrl #(.NSTG(NSTG), .DW(DW), .AW(AW), .SW_(SW_), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_wr(id_wr), .id_dst(id_dst),
    .id_rdy(id_rdy), .id_rs(id_rs), .id_rt(id_rt), .id_rs_use(id_rs_use),
    .id_rt_use(id_rt_use), .flush(flush), .stg_data(stg_data),
    .id_rs_dat(id_rs_dat), .id_rt_dat(id_rt_dat), .ex_rs_dat(ex_rs_dat),
    .ex_rt_dat(ex_rt_dat), .stall(stall), .id_rs_fwd(id_rs_fwd),
    .id_rt_fwd(id_rt_fwd), .ex_rs_fwd(ex_rs_fwd), .ex_rt_fwd(ex_rt_fwd),
    .ex_rs_hit(ex_rs_hit), .ex_rt_hit(ex_rt_hit), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic push(input string name, input logic [DW-1:0] v);
    exp_t x;
    x.name = name;
    x.val  = v;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_id(input logic v, input logic wr, input logic [AW-1:0] dst,
                        input logic [SW_-1:0] rdy, input logic [AW-1:0] rs,
                        input logic [AW-1:0] rt, input logic [1:0] rsu,
                        input logic [1:0] rtu);
    id_valid = v; id_wr = wr; id_dst = dst; id_rdy = rdy;
    id_rs = rs; id_rt = rt; id_rs_use = rsu; id_rt_use = rtu; flush = 1'b0;
  endtask

  task automatic bubble();
    set_id(1'b0, 1'b0, '0, '0, '0, '0, USE_NONE, USE_NONE);
  endtask

  task automatic set_stg(input int k, input logic [DW-1:0] v);
    stg_data[k*DW +: DW] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bubble();
    stg_data = '0;
    id_rs_dat = '0; id_rt_dat = '0; ex_rs_dat = '0; ex_rt_dat = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_id(1'b1, 1'b1, 5'd3, SW_'(RDY_LOAD), 5'd3, 5'd4, USE_ID, USE_EX);
    stg_data = {NSTG{32'hF0F0_1234}};
    id_rs_dat = 32'h11; id_rt_dat = 32'h22; ex_rs_dat = 32'h33; ex_rt_dat = 32'h44;
    repeat (2) @(negedge clk);
    settle();
    push("rst_stall", 0); push("rst_cnt", 0); push("rst_valid", 0);
    push("rst_id_rs", 32'h11); push("rst_ex_rt", 32'h44); push("rst_ex_rs_hit", 0);
    e = sb.pop_front(); n_total++;
    if (stall !== e.val[0]) $display("FAIL %s: got %0h want %0h", e.name, stall, e.val[0]); else n_pass++;
    e = sb.pop_front(); n_total++;
    if (stall_cnt !== e.val[CNTW-1:0]) $display("FAIL %s: got %0h want %0h", e.name, stall_cnt, e.val[CNTW-1:0]); else n_pass++;
    e = sb.pop_front(); n_total++;
    if (dut.s_valid !== e.val[NSTG-1:0]) $display("FAIL %s: got %0h want %0h", e.name, dut.s_valid, e.val[NSTG-1:0]); else n_pass++;
    e = sb.pop_front(); n_total++;
    if (id_rs_fwd !== e.val) $display("FAIL %s: got %0h want %0h", e.name, id_rs_fwd, e.val); else n_pass++;
    e = sb.pop_front(); n_total++;
    if (ex_rt_fwd !== e.val) $display("FAIL %s: got %0h want %0h", e.name, ex_rt_fwd, e.val); else n_pass++;
    e = sb.pop_front(); n_total++;
    if (ex_rs_hit !== e.val[0]) $display("FAIL %s: got %0h want %0h", e.name, ex_rs_hit, e.val[0]); else n_pass++;
  endtask

  // ALU writer r8: stalls an ID-use consumer in slot 0, forwards from slot 1.
  task automatic test_id_forward();
    do_reset();
    set_id(1'b1, 1'b1, 5'd8, SW_'(RDY_ALU), '0, '0, USE_NONE, USE_NONE);
    tick();
    set_id(1'b1, 1'b0, '0, SW_'(RDY_ALU), 5'd8, 5'd0, USE_ID, USE_ID);
    id_rs_dat = 32'h0BAD; id_rt_dat = 32'h5A5A;
    settle();
    push("idf_stall_slot0", 1);
    e = sb.pop_front(); n_total++;
    if (stall !== e.val[0]) $display("FAIL %s: got %0h want %0h", e.name, stall, e.val[0]); else n_pass++;
    tick();
    set_stg(1, 32'h1234);
    settle();
    push("idf_stall_slot1", 0); push("idf_rs_fwd", 32'h1234); push("idf_rt_pass", 32'h5A5A);
    push("idf_cnt", 1);
    e = sb.pop_front(); n_total++;
    if (stall !== e.val[0]) $display("FAIL %s: got %0h want %0h", e.name, stall, e.val[0]); else n_pass++;
    e = sb.pop_front(); n_total++;
    if (id_rs_fwd !== e.val) $display("FAIL %s: got %0h want %0h", e.name, id_rs_fwd, e.val); else n_pass++;
    e = sb.pop_front(); n_total++;
    if (id_rt_fwd !== e.val) $display("FAIL %s: got %0h want %0h", e.name, id_rt_fwd, e.val); else n_pass++;
    e = sb.pop_front(); n_total++;
    if (stall_cnt !== e.val[CNTW-1:0]) $display("FAIL %s: got %0h want %0h", e.name, stall_cnt, e.val[CNTW-1:0]); else n_pass++;
  endtask

  // Load r9 then EX-use consumer: one stall, bubble, then EX forward from slot 2.
  task automatic test_load_use();
    do_reset();
    set_id(1'b1, 1'b1, 5'd9, SW_'(RDY_LOAD), '0, '0, USE_NONE, USE_NONE);
    tick();
    set_id(1'b1, 1'b1, 5'd10, SW_'(RDY_ALU), 5'd9, 5'd0, USE_EX, USE_NONE);
    id_rs_dat = 32'h1111;
    set_stg(1, 32'h9999);
    settle();
    push("lu_stall", 1); push("lu_cnt0", 0);
    e = sb.pop_front(); n_total++;
    if (stall !== e.val[0]) $display("FAIL %s: got %0h want %0h", e.name, stall, e.val[0]); else n_pass++;
    e = sb.pop_front(); n_total++;
    if (stall_cnt !== e.val[CNTW-1:0]) $display("FAIL %s: got %0h want %0h", e.name, stall_cnt, e.val[CNTW-1:0]); else n_pass++;
    tick();
    settle();
    push("lu_bubble", 0); push("lu_cnt1", 1); push("lu_nostall", 0); push("lu_id_nofwd", 32'h1111);
    e = sb.pop_front(); n_total++;
    if (dut.s_valid[0] !== e.val[0]) $display("FAIL %s: got %0h want %0h", e.name, dut.s_valid[0], e.val[0]); else n_pass++;
    e = sb.pop_front(); n_total++;
    if (stall_cnt !== e.val[CNTW-1:0]) $display("FAIL %s: got %0h want %0h", e.name, stall_cnt, e.val[CNTW-1:0]); else n_pass++;
    e = sb.pop_front(); n_total++;
    if (stall !== e.val[0]) $display("FAIL %s: got %0h want %0h", e.name, stall, e.val[0]); else n_pass++;
    e = sb.pop_front(); n_total++;
    if (id_rs_fwd !== e.val) $display("FAIL %s: got %0h want %0h", e.name, id_rs_fwd, e.val); else n_pass++;
    tick();
    bubble();
    set_stg(2, 32'hCAFE); ex_rs_dat = 32'h5555; ex_rt_dat = 32'h6666;
    settle();
    push("lu_ex_rs_fwd", 32'hCAFE); push("lu_ex_rs_hit", 1); push("lu_ex_rt_pass", 32'h6666);
    e = sb.pop_front(); n_total++;
    if (ex_rs_fwd !== e.val) $display("FAIL %s: got %0h want %0h", e.name, ex_rs_fwd, e.val); else n_pass++;
    e = sb.pop_front(); n_total++;
    if (ex_rs_hit !== e.val[0]) $display("FAIL %s: got %0h want %0h", e.name, ex_rs_hit, e.val[0]); else n_pass++;
    e = sb.pop_front(); n_total++;
    if (ex_rt_fwd !== e.val) $display("FAIL %s: got %0h want %0h", e.name, ex_rt_fwd, e.val); else n_pass++;
  endtask

  // Two writers of r4: EX takes the youngest; an unready producer gives no hit.
  task automatic test_ex_youngest();
    do_reset();
    set_id(1'b1, 1'b1, 5'd4, SW_'(RDY_ALU), '0, '0, USE_NONE, USE_NONE);
    tick();
    tick();
    set_id(1'b1, 1'b0, '0, SW_'(RDY_ALU), 5'd4, '0, USE_EX, USE_NONE);
    settle();
    push("exy_nostall", 0);
    e = sb.pop_front(); n_total++;
    if (stall !== e.val[0]) $display("FAIL %s: got %0h want %0h", e.name, stall, e.val[0]); else n_pass++;
    tick();
    bubble();
    set_stg(1, 32'hAA); set_stg(2, 32'hBB); ex_rs_dat = 32'h1;
    settle();
    push("exy_fwd", 32'hAA); push("exy_hit", 1);
    e = sb.pop_front(); n_total++;
    if (ex_rs_fwd !== e.val) $display("FAIL %s: got %0h want %0h", e.name, ex_rs_fwd, e.val); else n_pass++;
    e = sb.pop_front(); n_total++;
    if (ex_rs_hit !== e.val[0]) $display("FAIL %s: got %0h want %0h", e.name, ex_rs_hit, e.val[0]); else n_pass++;
    do_reset();
    set_id(1'b1, 1'b1, 5'd7, SW_'(RDY_LOAD), '0, '0, USE_NONE, USE_NONE);
    tick();
    set_id(1'b1, 1'b0, '0, SW_'(RDY_ALU), 5'd7, '0, USE_NONE, USE_NONE);
    tick();
    bubble();
    set_stg(1, 32'h7777); ex_rs_dat = 32'h4242;
    settle();
    push("exu_pass", 32'h4242); push("exu_nohit", 0);
    e = sb.pop_front(); n_total++;
    if (ex_rs_fwd !== e.val) $display("FAIL %s: got %0h want %0h", e.name, ex_rs_fwd, e.val); else n_pass++;
    e = sb.pop_front(); n_total++;
    if (ex_rs_hit !== e.val[0]) $display("FAIL %s: got %0h want %0h", e.name, ex_rs_hit, e.val[0]); else n_pass++;
  endtask

  // Youngest writer unready: stall persists despite an older ready writer.
  task automatic test_youngest_unready();
    do_reset();
    set_id(1'b1, 1'b1, 5'd5, SW_'(RDY_ALU), '0, '0, USE_NONE, USE_NONE);
    tick();
    set_id(1'b1, 1'b1, 5'd5, SW_'(RDY_LOAD), '0, '0, USE_NONE, USE_NONE);
    tick();
    set_id(1'b1, 1'b0, '0, SW_'(RDY_ALU), 5'd5, '0, USE_ID, USE_NONE);
    set_stg(1, 32'h66); set_stg(2, 32'h66); set_stg(3, 32'h66);
    settle();
    push("yu_stall0", 1);
    e = sb.pop_front(); n_total++;
    if (stall !== e.val[0]) $display("FAIL %s: got %0h want %0h", e.name, stall, e.val[0]); else n_pass++;
    tick();
    settle();
    push("yu_stall1", 1);
    e = sb.pop_front(); n_total++;
    if (stall !== e.val[0]) $display("FAIL %s: got %0h want %0h", e.name, stall, e.val[0]); else n_pass++;
    tick();
    set_stg(2, 32'h77);
    settle();
    push("yu_stall2", 0); push("yu_fwd", 32'h77); push("yu_cnt", 2);
    e = sb.pop_front(); n_total++;
    if (stall !== e.val[0]) $display("FAIL %s: got %0h want %0h", e.name, stall, e.val[0]); else n_pass++;
    e = sb.pop_front(); n_total++;
    if (id_rs_fwd !== e.val) $display("FAIL %s: got %0h want %0h", e.name, id_rs_fwd, e.val); else n_pass++;
    e = sb.pop_front(); n_total++;
    if (stall_cnt !== e.val[CNTW-1:0]) $display("FAIL %s: got %0h want %0h", e.name, stall_cnt, e.val[CNTW-1:0]); else n_pass++;
  endtask

  // Writes to r0 never match in ID or EX.
  task automatic test_reg_zero();
    do_reset();
    set_id(1'b1, 1'b1, 5'd0, SW_'(RDY_LOAD), '0, '0, USE_NONE, USE_NONE);
    tick();
    bubble();
    tick();
    set_id(1'b1, 1'b0, '0, SW_'(RDY_ALU), 5'd0, 5'd0, USE_ID, USE_ID);
    set_stg(1, 32'hDEAD); set_stg(2, 32'hDEAD);
    settle();
    push("r0_nostall", 0); push("r0_id_fwd", 0);
    e = sb.pop_front(); n_total++;
    if (stall !== e.val[0]) $display("FAIL %s: got %0h want %0h", e.name, stall, e.val[0]); else n_pass++;
    e = sb.pop_front(); n_total++;
    if (id_rs_fwd !== e.val) $display("FAIL %s: got %0h want %0h", e.name, id_rs_fwd, e.val); else n_pass++;
    tick();
    bubble();
    ex_rs_dat = 32'h0;
    settle();
    push("r0_ex_nohit", 0);
    e = sb.pop_front(); n_total++;
    if (ex_rs_hit !== e.val[0]) $display("FAIL %s: got %0h want %0h", e.name, ex_rs_hit, e.val[0]); else n_pass++;
  endtask

  // Flush suppresses the stall; reset mid-stall clears at once.
  task automatic test_flush_reset();
    do_reset();
    set_id(1'b1, 1'b1, 5'd9, SW_'(4), '0, '0, USE_NONE, USE_NONE);
    tick();
    set_id(1'b1, 1'b0, '0, SW_'(RDY_ALU), 5'd9, '0, USE_ID, USE_NONE);
    flush = 1'b1;
    settle();
    push("fl_nostall", 0);
    e = sb.pop_front(); n_total++;
    if (stall !== e.val[0]) $display("FAIL %s: got %0h want %0h", e.name, stall, e.val[0]); else n_pass++;
    tick();
    flush = 1'b0;
    settle();
    push("fl_bubble", 0);
    e = sb.pop_front(); n_total++;
    if (dut.s_valid[0] !== e.val[0]) $display("FAIL %s: got %0h want %0h", e.name, dut.s_valid[0], e.val[0]); else n_pass++;
    tick();
    settle();
    push("mr_stall_before", 1); push("mr_cnt_before", 1);
    e = sb.pop_front(); n_total++;
    if (stall !== e.val[0]) $display("FAIL %s: got %0h want %0h", e.name, stall, e.val[0]); else n_pass++;
    e = sb.pop_front(); n_total++;
    if (stall_cnt !== e.val[CNTW-1:0]) $display("FAIL %s: got %0h want %0h", e.name, stall_cnt, e.val[CNTW-1:0]); else n_pass++;
    rst = 1'b1;
    #1;
    push("mr_valid", 0); push("mr_cnt", 0); push("mr_stall", 0);
    e = sb.pop_front(); n_total++;
    if (dut.s_valid !== e.val[NSTG-1:0]) $display("FAIL %s: got %0h want %0h", e.name, dut.s_valid, e.val[NSTG-1:0]); else n_pass++;
    e = sb.pop_front(); n_total++;
    if (stall_cnt !== e.val[CNTW-1:0]) $display("FAIL %s: got %0h want %0h", e.name, stall_cnt, e.val[CNTW-1:0]); else n_pass++;
    e = sb.pop_front(); n_total++;
    if (stall !== e.val[0]) $display("FAIL %s: got %0h want %0h", e.name, stall, e.val[0]); else n_pass++;
    rst = 1'b0;
    tick();
    settle();
    push("mr_shift", 1);
    e = sb.pop_front(); n_total++;
    if (dut.s_valid[0] !== e.val[0]) $display("FAIL %s: got %0h want %0h", e.name, dut.s_valid[0], e.val[0]); else n_pass++;
  endtask

  // Self-dependent slow producer stalls NSTG of every NSTG+1 cycles until saturation.
  task automatic test_saturate();
    int            c;
    int            nstalls;
    int            perr;
    logic          mstall;
    logic [CNTW-1:0] mcnt;
    do_reset();
    set_id(1'b1, 1'b1, 5'd1, SW_'(15), 5'd1, '0, USE_ID, USE_NONE);
    c = 0; nstalls = 0; perr = 0; mcnt = '0;
    while (nstalls < (1 << CNTW) + 3 && c < 90000) begin
      settle();
      mstall = (c % (NSTG + 1)) != 0;
      if (stall !== mstall) perr++;
      if (c == 1000) begin
        push("sat_mid_cnt", DW'(mcnt));
        e = sb.pop_front(); n_total++;
        if (stall_cnt !== e.val[CNTW-1:0]) $display("FAIL %s: got %0h want %0h", e.name, stall_cnt, e.val[CNTW-1:0]); else n_pass++;
      end
      tick();
      if (mstall) begin
        nstalls++;
        if (mcnt != '1) mcnt = mcnt + CNTW'(1);
      end
      c++;
    end
    settle();
    push("sat_pattern_errs", 0); push("sat_cnt", 32'hFFFF);
    e = sb.pop_front(); n_total++;
    if (DW'(perr) !== e.val) $display("FAIL %s: got %0d want %0d", e.name, perr, e.val); else n_pass++;
    e = sb.pop_front(); n_total++;
    if (stall_cnt !== e.val[CNTW-1:0]) $display("FAIL %s: got %0h want %0h", e.name, stall_cnt, e.val[CNTW-1:0]); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_id_forward();
    test_load_use();
    test_ex_youngest();
    test_youngest_unready();
    test_reg_zero();
    test_flush_reset();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard/forwarding controller for the in-order CPU pipeline. It keeps a shadow tag pipeline of NSTG post-decode slots (slot 0 = EX … slot NSTG-1 = WB) and generates the decode stall. It produces forwarding selects and data for the ID-stage consumer (branch compare, jr) and the EX-stage consumer (ALU operands). Unlike the fixed two-level forward chains, source-use timing and producer latency are per-instruction inputs, and it adds $0 suppression, flush and a stall counter.

Parameters:
NSTG, 3, tracked slots after ID (min 2, max 8)
DW, 32, datapath width
AW, 5, register index width
SW_, $clog2(NSTG)+1, width of ready-stage/select fields
CNTW, 16, stall counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
id_valid  in  1  ID holds a real instruction (not a bubble)
id_wr  in  1  ID instruction writes a register
id_dst  in  AW  ID destination register
id_rdy  in  SW_  slot index at which the ID instruction's result is first valid (ALU=1, load=2)
id_rs, id_rt  in  AW  ID source registers
id_rs_use, id_rt_use  in  2  0=unused, 1=needed in ID, 2=needed in EX
flush  in  1  kill the ID instruction (it enters slot 0 as a bubble)
stg_data  in  NSTG*DW  result currently held in each slot; slot k at [k*DW +: DW]
id_rs_dat, id_rt_dat  in  DW  regfile read data
ex_rs_dat, ex_rt_dat  in  DW  operands latched into EX
stall  out  1  hold PC and IF/ID; combinational
id_rs_fwd, id_rt_fwd  out  DW  forwarded ID operands
ex_rs_fwd, ex_rt_fwd  out  DW  forwarded EX operands
ex_rs_hit, ex_rt_hit  out  1  EX operand came from a slot (debug/LCD)
stall_cnt  out  CNTW  saturating count of stall cycles

Behaviour:
- Slot entry = {valid, wr, dst, rdy, rs, rt}. A slot "writes r" when valid & wr & dst==r & r!=0.
- Register 0 never matches. Its forward outputs pass the input data unchanged.
- Producer selection: among the slots that write r, the lowest index (youngest) wins. Older matches are ignored.
- ID-use hazard (use==1): stall if the youngest writer of the source in slot k has k < its rdy.
  - Otherwise forward stg_data[k].
  - With no writer, pass id_*_dat.
- EX-use hazard (use==2): stall if the youngest writer in slot k has k+1 < its rdy (not ready when the consumer reaches EX).
  - ID operands are not forwarded for EX-use sources.
- stall = OR over both sources of the hazard terms, gated by id_valid & !flush. A flushed ID never stalls.
- EX forwarding: slot 0 sources are checked against slots 1..NSTG-1 (youngest first).
  - Data is taken only from a slot index >= that writer's rdy. Otherwise ex_*_fwd = ex_*_dat and hit=0.
  - A correctly stalled pipe never leaves slot 0 with an unready producer.
- Advance on every posedge: slots 1..NSTG-1 <= slots 0..NSTG-2.
- Slot 0 <= ID entry with valid = id_valid & !flush & !stall. A stall inserts a bubble; flush and stall together also give a bubble.
- stall_cnt increments on each posedge where stall=1. It saturates at all-ones and does not wrap.
- Reset (async): all slot valid=0, other fields 0, stall_cnt=0. Outputs after reset: stall=0, forwards = pass-through inputs, hits=0.
- Reset mid-stall clears immediately. The first clock after release shifts normally.
- Same dst in several slots: only the youngest is used, even if it is unready. That case stalls; no fallback to an older ready writer.

Decomposition:
- Shared package/header: use-code constants (USE_NONE=0, USE_ID=1, USE_EX=2) and ready-stage constants (RDY_ALU=1, RDY_LOAD=2) added to the existing header defines.
- One sub-module, fwd_pick: a parametrised youngest-match priority selector returning {hit, idx, ready} for one source against a slot range. It is instantiated four times (ID rs/rt, EX rs/rt).
- Slot storage and the counter stay in the top.

Test Plan:
1. ALU writer r8 in slot 1 (rdy=1); ID beq uses r8 at ID (use=1), stg_data slot1=0x1234 -> stall=0, id_rs_fwd=0x1234.
2. Load writer r9 in slot 0 (rdy=2); ID add uses r9 at EX (use=2) -> stall=1 for one cycle, slot 0 gets a bubble, stall_cnt 0->1. Next cycle (load in slot 1) -> stall=0.
3. Writers of r4 in slot 1 (data 0xAA) and slot 2 (data 0xBB); EX consumer rs=r4 -> ex_rs_fwd=0xAA, ex_rs_hit=1.
4. Writer to r0 in slot 1, ID rs=r0, id_rs_dat=0 -> no stall, id_rs_fwd=0, no hit.
5. Hazard condition present with flush=1 -> stall=0, slot 0 valid=0 after the clock. Then assert rst mid-stall -> all slots invalid and stall_cnt=0 immediately.
6. Force stall for 2^CNTW+3 cycles -> stall_cnt holds at 0xFFFF.
